// File: rtl/paddle_ctrl.sv
// Two-player paddle controller: raw buttons are synchronised and debounced,
// then step each paddle top line under a WAIT/PLAY/OVER game FSM.
module paddle_ctrl #(
  parameter int V_DISP   = 480,
  parameter int SLDE_W   = 10,
  parameter int BODY_L   = 80,
  parameter int MOVE_DIV = 120000,
  parameter int DEB_LEN  = 250000
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [3:0] score,
  input  logic       p0_up,
  input  logic       p0_dn,
  input  logic       p1_up,
  input  logic       p1_dn,
  output logic [9:0] padbody_y0,
  output logic [9:0] padbody_y1
);
  localparam int DW = $clog2(DEB_LEN + 1);
  localparam int TW = $clog2(MOVE_DIV + 1);
  localparam logic [10:0] CENTER = 11'(V_DISP / 2 - BODY_L / 2);
  localparam logic [10:0] YMIN   = 11'(SLDE_W + 1);
  localparam logic [10:0] YMAX   = 11'(V_DISP - SLDE_W - BODY_L - 1);

  localparam logic [1:0] WAIT = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] OVER = 2'd2;

  // Button order everywhere: {p1_dn, p1_up, p0_dn, p0_up}
  logic [3:0] raw;
  logic [3:0] sync_a;
  logic [3:0] sync_b;
  logic [3:0] deb;

  assign raw = {p1_dn, p1_up, p0_dn, p0_up};

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_deb
      logic [DW-1:0] cnt;
      logic          lvl;

      // Level flips only after DEB_LEN consecutive disagreeing samples.
      always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
          cnt <= '0;
          lvl <= 1'b0;
        end else if (sync_b[gi] == lvl) begin
          cnt <= '0;
        end else if (cnt == DW'(DEB_LEN - 1)) begin
          lvl <= ~lvl;
          cnt <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end

      assign deb[gi] = lvl;
    end
  endgenerate

  logic [TW-1:0] tick;
  logic          move_tick;

  assign move_tick = (tick == TW'(MOVE_DIV - 1));

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tick <= '0;
    end else if (move_tick) begin
      tick <= '0;
    end else begin
      tick <= tick + TW'(1);
    end
  end

  logic [1:0] state;
  logic [1:0] state_next;
  logic       game_over;

  assign game_over = (score[3:2] == 2'b11) || (score[1:0] == 2'b11);

  // Dropping start takes priority over a simultaneous game-over.
  always_comb begin
    state_next = state;
    case (state)
      WAIT: if (start && !game_over) state_next = PLAY;
      PLAY: begin
        if (!start) begin
          state_next = WAIT;
        end else if (game_over) begin
          state_next = OVER;
        end
      end
      OVER: if (!start) state_next = WAIT;
      default: state_next = WAIT;
    endcase
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= WAIT;
    end else begin
      state <= state_next;
    end
  end

  function automatic logic [10:0] step_pos(input logic [10:0] y,
                                           input logic up,
                                           input logic dn);
    logic [10:0] r;
    r = y;
    if (up && !dn && (y > YMIN)) begin
      r = y - 11'd1;
    end else if (dn && !up && (y < YMAX)) begin
      r = y + 11'd1;
    end
    return r;
  endfunction

  logic [10:0] y0_cur;
  logic [10:0] y1_cur;
  logic [10:0] y0_next;
  logic [10:0] y1_next;
  logic        unused_msb;

  assign y0_cur = {1'b0, padbody_y0};
  assign y1_cur = {1'b0, padbody_y1};

  always_comb begin
    y0_next = y0_cur;
    y1_next = y1_cur;
    case (state)
      WAIT: begin
        y0_next = CENTER;
        y1_next = CENTER;
      end
      PLAY: begin
        if (move_tick) begin
          y0_next = step_pos(y0_cur, deb[0], deb[1]);
          y1_next = step_pos(y1_cur, deb[2], deb[3]);
        end
      end
      default: begin
        y0_next = y0_cur;
        y1_next = y1_cur;
      end
    endcase
  end

  // Clamping keeps positions below 512, so the top bit is always zero.
  assign unused_msb = y0_next[10] ^ y1_next[10];

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      padbody_y0 <= CENTER[9:0];
      padbody_y1 <= CENTER[9:0];
    end else begin
      padbody_y0 <= y0_next[9:0];
      padbody_y1 <= y1_next[9:0];
    end
  end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter V_DISP, default 480: visible lines per frame.
REQ-002 Parameter SLDE_W, default 10: wall (border) thickness in lines.
REQ-003 Parameter BODY_L, default 80: paddle length in lines.
REQ-004 Parameter MOVE_DIV, default 120000: clocks per paddle move step.
REQ-005 Parameter DEB_LEN, default 250000: debounce stability window in clocks.
REQ-006 vga_clk  input  1  pixel clock; the single clock; all logic on its rising edge.
REQ-007 sys_rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  game-enable level; low = idle/recenter.
REQ-009 score  input  4  ball block score: [3:2] right-wall points, [1:0] left-wall points.
REQ-010 p0_up, p0_dn  input  1 each  raw asynchronous buttons for the left paddle, active high.
REQ-011 p1_up, p1_dn  input  1 each  raw asynchronous buttons for the right paddle, active high.
REQ-012 padbody_y0  output  10  left paddle top line, registered.
REQ-013 padbody_y1  output  10  right paddle top line, registered.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Each synced button SHALL have its own debounce counter and debounced level.
REQ-016 The debounce counter clears whenever synced == debounced level; otherwise it increments.
REQ-017 The debounced level toggles, and its counter clears, on the clock where the counter reaches DEB_LEN-1.
REQ-018 Net debounce latency from a stable input edge to a debounced edge SHALL be 2 + DEB_LEN clocks.
REQ-019 A free-running tick counter SHALL count 0..MOVE_DIV-1 and wrap to 0.
REQ-020 move_tick is asserted for exactly one clock, when the tick counter == MOVE_DIV-1.
REQ-021 The game FSM SHALL have three states: WAIT, PLAY and OVER.
REQ-022 WAIT -> PLAY when start=1 and game_over=0, where game_over = (score[3:2]==3) or (score[1:0]==3).
REQ-023 PLAY -> OVER when game_over=1; PLAY -> WAIT when start=0; the start=0 transition wins if both occur together.
REQ-024 OVER -> WAIT when start=0; otherwise the FSM stays in OVER.
REQ-025 In WAIT, both paddles SHALL be loaded with CENTER = V_DISP/2 - BODY_L/2 (200 at defaults) on every clock.
REQ-026 In OVER, both paddles SHALL hold their position.
REQ-027 In PLAY, on move_tick each paddle SHALL take the direction decoded from its debounced buttons: up&~dn = up, dn&~up = down, both or neither = hold.
REQ-028 Moving up SHALL subtract 1, only if y > YMIN = SLDE_W+1 (11 at defaults).
REQ-029 Moving down SHALL add 1, only if y < YMAX = V_DISP-SLDE_W-BODY_L-1 (389 at defaults).
REQ-030 Position arithmetic and compares SHALL be done at 11 bits, unsigned; a paddle never wraps or leaves [YMIN, YMAX].
REQ-031 The two paddles SHALL move independently on the same tick.
REQ-032 Button activity outside PLAY SHALL still be debounced but SHALL NOT move either paddle.
REQ-033 start dropping mid-game SHALL recenter both paddles one clock after the FSM enters WAIT.

Reset
REQ-034 While sys_rst=1, the module SHALL hold the following values:
- synchronizers, debounced levels and all counters = 0;
- FSM = WAIT;
- padbody_y0 = padbody_y1 = CENTER.
REQ-035 On sys_rst deassertion, the module SHALL resume in WAIT with no spurious move.

Verification (benches override DEB_LEN=4, MOVE_DIV=2)
REQ-036 Reset and idle: assert sys_rst mid-play with the paddle at 150 -> padbody_y0 = 200 immediately; release with start=0 -> both outputs stay at 200.
REQ-037 Upper stop: start=1, hold p0_up -> first decrement no earlier than 6 clocks after the press, then 1 step per 2 clocks, stopping at 11 and never reaching 10.
REQ-038 Lower stop: start=1, hold p1_dn -> padbody_y1 climbs to 389 and holds while padbody_y0 stays at 200.
REQ-039 Glitch rejection: pulse p0_dn for 3 clocks -> padbody_y0 unchanged; then hold both p0_up and p0_dn -> no movement.
REQ-040 Game over then restart: during PLAY with paddles at 150 and 300, drive score=4'b1100 -> both freeze.
- Then drop start -> both outputs read 200 within 2 clocks.
- Then raise start with score=0 -> PLAY resumes.
